pipe_ctrl: RTL

- Central pipeline control unit for the 5-stage RV core.
- Initiator side of the per-stage en/flush interface: drives en and flush into pc, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Resolves load-use hazards, taken jumps/branches, multi-cycle data-memory stalls and WB-stage halt (ecall).
- Also owns the halt/error state machine, a dmem watchdog and stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 32 +++
 rtl/pipe_ctrl_hazard_detect.sv | 23 ++
 rtl/pipe_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
// Holds the controller state encoding and the stage enable/flush bundle.
package pipe_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  // One bit per pipeline register, ordered front to back.
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_vec_t;

  localparam stage_vec_t STAGES_ALL  = '{pc: 1'b1, if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b1};
  localparam stage_vec_t STAGES_NONE = '{pc: 1'b0, if_id: 1'b0, id_ex: 1'b0, ex_mem: 1'b0, mem_wb: 1'b0};

  // A load result is needed by ID before it exists: rd must match a source
  // the ID instruction actually reads, and x0 never creates a dependency.
  function automatic logic src_hit(input logic uses, input logic [REG_AW-1:0] src,
                                   input logic [REG_AW-1:0] rd);
    return uses && (src == rd);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use comparator between the load in EX and the
// instruction in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  output logic              load_use
);

  logic rd_nonzero;

  assign rd_nonzero = (ex_rd_addr != '0);

  assign load_use = ex_mem_read && rd_nonzero &&
                    (src_hit(id_uses_rs1, id_rs1_addr, ex_rd_addr) ||
                     src_hit(id_uses_rs2, id_rs2_addr, ex_rd_addr));

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stage enables/flushes, RUN/HALT/ERR state,
// dmem watchdog and stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              jump_ex,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  input  logic              halt_req,
  input  logic              resume,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mem_wb_flush,
  output logic              halted,
  output logic              error,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;

  stage_vec_t en, flush;
  logic       halted_o, error_o;
  logic       load_use, mem_stall;

  hazard_detect u_hazard_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd_addr  (ex_rd_addr),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .load_use    (load_use)
  );

  assign mem_stall = dmem_req && !dmem_ready;

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no
    // path through the case can leave one unassigned and infer a latch.
    en          = STAGES_ALL;
    flush       = STAGES_NONE;
    halted_o    = 1'b0;
    error_o     = 1'b0;
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wdog_d      = wdog_q;

    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          // Freeze everything ahead of MEM; jump and load-use wait for release.
          en.pc        = 1'b0;
          en.if_id     = 1'b0;
          en.id_ex     = 1'b0;
          en.ex_mem    = 1'b0;
          flush.mem_wb = 1'b1;
          stall_cnt_d  = stall_cnt_q + 1'b1;
          wdog_d       = wdog_q + 1'b1;
        end else begin
          wdog_d = '0;
          if (jump_ex) begin
            flush.if_id = 1'b1;
            flush.id_ex = 1'b1;
            flush_cnt_d = flush_cnt_q + 1'b1;
          end else if (load_use) begin
            en.pc       = 1'b0;
            en.if_id    = 1'b0;
            flush.id_ex = 1'b1;
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end

        if (mem_stall && (wdog_q == WD_LAST)) begin
          state_d = ST_ERR;
        end else if (halt_req) begin
          state_d = ST_HALT;
        end
      end

      ST_HALT: begin
        en       = STAGES_NONE;
        halted_o = 1'b1;
        if (resume) begin
          state_d = ST_RUN;
        end
      end

      ST_ERR: begin
        en      = STAGES_NONE;
        error_o = 1'b1;
      end

      default: begin
        en      = STAGES_NONE;
        state_d = ST_RUN;
      end
    endcase

    // The pipeline runs unhindered while reset is held.
    if (rst) begin
      en       = STAGES_ALL;
      flush    = STAGES_NONE;
      halted_o = 1'b0;
      error_o  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wdog_q      <= wdog_d;
    end
  end

  assign pc_en        = en.pc;
  assign if_id_en     = en.if_id;
  assign id_ex_en     = en.id_ex;
  assign ex_mem_en    = en.ex_mem;
  assign mem_wb_en    = en.mem_wb;
  assign if_id_flush  = flush.if_id;
  assign id_ex_flush  = flush.id_ex;
  assign ex_mem_flush = flush.ex_mem;
  assign mem_wb_flush = flush.mem_wb;
  assign halted       = halted_o;
  assign error        = error_o;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule
